// File: rtl/dcache_assoc.sv
// dcache_assoc: write-back, write-allocate, set-associative data cache
// controller between the MEM stage and a line-wide data memory.
//
// Hits are served combinationally with no stall. A miss stalls the CPU,
// writes back a dirty victim if one must be evicted, refills the line and
// then lets the held request complete as an ordinary hit.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), async active-low reset
//   p1_addr_i/p1_data_i    CPU byte address / write data
//   p1_MemRead_i/_MemWrite_i  CPU request (both high behaves as a write)
//   p1_data_o              read data, zero unless a read hit
//   p1_stall_o             pipeline freeze (combinational)
//   mem_addr_o/mem_data_o  line-aligned memory address / writeback line
//   mem_enable_o           memory request, mem_write_o 1=writeback 0=refill
//   mem_data_i/mem_ack_i   refill line / one-cycle completion pulse
//   hit_cnt_o/miss_cnt_o   saturating hit and miss counters
module dcache_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BSEL_W = $clog2(DATA_W / 8);
  localparam int WORDS  = LINE_W / DATA_W;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_nxt;

  logic [WAYS-1:0]   valid [SETS];
  logic [WAYS-1:0]   dirty [SETS];
  logic [PTR_W-1:0]  ptr   [SETS];
  logic [TAG_W-1:0]  tags  [SETS][WAYS];
  logic [LINE_W-1:0] lines [SETS][WAYS];

  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic [PTR_W-1:0]  lat_way;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [WAYS-1:0]   match;
  logic [PTR_W-1:0]  hit_way, victim;
  logic              found_inv, victim_dirty;
  logic              req, is_idle, hit, miss, install;
  logic              unused_bsel;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign idx         = p1_addr_i[OFF_W +: IDX_W];
  assign tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel        = p1_addr_i[BSEL_W +: WSEL_W];
  assign unused_bsel = ^p1_addr_i[BSEL_W-1:0];

  // Tag compare; the descending scan leaves the lowest matching way.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w] = valid[idx][w] && (tags[idx][w] == tag);
      if (match[w]) hit_way = PTR_W'(w);
    end
  end

  // Victim: lowest invalid way, else the round-robin pointer.
  always_comb begin
    victim    = ptr[idx];
    found_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) begin
        victim    = PTR_W'(w);
        found_inv = 1'b1;
      end
    end
  end

  assign victim_dirty = valid[idx][victim] & dirty[idx][victim];

  // Requests are masked during reset so stall and read data stay low.
  assign req        = rst_i & (p1_MemRead_i | p1_MemWrite_i);
  assign is_idle    = (state == IDLE);
  assign hit        = req & is_idle & (|match);
  assign miss       = req & is_idle & ~(|match);
  assign install    = (state == ALLOCATE) & mem_ack_i;
  assign p1_stall_o = req & (~is_idle | miss);
  assign p1_data_o  = (hit && !p1_MemWrite_i) ?
                      lines[idx][hit_way][wsel*DATA_W +: DATA_W] : '0;

  // Memory outputs come only from latched fields, so they hold steady
  // for the whole transaction.
  always_comb begin
    state_nxt    = state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state)
      IDLE: begin
        if (miss) state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tags[lat_idx][lat_way], lat_idx, {OFF_W{1'b0}}};
        mem_data_o   = lines[lat_idx][lat_way];
        if (mem_ack_i) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {lat_tag, lat_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        ptr[s]   <= '0;
      end
    end else begin
      state <= state_nxt;
      if (hit) hit_cnt_o <= sat_inc(hit_cnt_o);
      if (hit && p1_MemWrite_i) dirty[idx][hit_way] <= 1'b1;
      if (miss) begin
        miss_cnt_o <= sat_inc(miss_cnt_o);
        if (!found_inv && WAYS > 1) ptr[idx] <= ptr[idx] + 1'b1;
      end
      if (install) begin
        valid[lat_idx][lat_way] <= 1'b1;
        dirty[lat_idx][lat_way] <= 1'b0;
      end
    end
  end

  // Tag/line storage and miss latches carry no reset; an install is gated
  // by the reset-cleared state, so an aborted refill never lands.
  always_ff @(posedge clk_i) begin
    if (miss) begin
      lat_idx <= idx;
      lat_tag <= tag;
      lat_way <= victim;
    end
    if (hit && p1_MemWrite_i) lines[idx][hit_way][wsel*DATA_W +: DATA_W] <= p1_data_i;
    if (install) begin
      lines[lat_idx][lat_way] <= mem_data_i;
      tags[lat_idx][lat_way]  <= lat_tag;
    end
  end
endmodule
